// File: rtl/ahbl_stall_sram_if.sv
// AHB-Lite bus bundle between a manager (or harness) and the stalling SRAM subordinate.
// hready is the bus-level HREADY; hready_resp is the subordinate's HREADYOUT.
interface ahbl_stall_sram_if #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
);
  logic              hready;
  logic              hready_resp;
  logic              hresp;
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;

  modport master (
    output hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
    input  hready_resp, hresp, hrdata
  );

  modport slave (
    input  hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
    output hready_resp, hresp, hrdata
  );
endinterface

// File: rtl/ahbl_stall_sram.sv
// AHB-Lite SRAM model with LFSR-driven wait states and an address-mapped error window.
// Exercises manager-side stall and two-cycle error handling with concrete programs.
module ahbl_stall_sram #(
  parameter int unsigned       W_ADDR     = 32,
  parameter int unsigned       W_DATA     = 32,
  parameter int unsigned       DEPTH      = 4096,
  parameter logic [7:0]        STALL_MASK = 8'd3,
  parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
  parameter logic [W_ADDR-1:0] ERR_BASE   = 32'hF000_0000,
  parameter logic [W_ADDR-1:0] ERR_SIZE   = 32'h1000
) (
  input logic               clk,
  input logic               rst_n,
  input logic               stall_en,
  ahbl_stall_sram_if.slave  ahbls
);

  localparam int unsigned NBytes = W_DATA / 8;
  localparam int unsigned OffW   = $clog2(NBytes);
  localparam int unsigned IdxW   = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [IdxW-1:0]   word_q, word_d;
  logic [OffW-1:0]   off_q, off_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              err_q, err_d;

  logic [W_DATA-1:0] mem_q [DEPTH];

  logic              ready_int;
  logic              accept;
  logic              err_in;
  logic [W_ADDR-1:0] err_rel;
  logic [7:0]        stall;
  logic [15:0]       lfsr_step;
  logic [NBytes-1:0] lane_mask;
  logic [W_DATA-1:0] wr_word;
  logic              mem_we;

  assign ready_int = (state_q != StWait) && (state_q != StErr1);
  assign accept    = ahbls.hready && ahbls.htrans[1] && ready_int;

  // Error on: inside the error window, wider than the bus, or not size-aligned.
  always_comb begin
    err_rel = ahbls.haddr - ERR_BASE;
    err_in  = ((ERR_SIZE != '0) && (ahbls.haddr >= ERR_BASE) && (err_rel < ERR_SIZE)) ||
              (ahbls.hsize > 3'(OffW)) ||
              ((ahbls.haddr[6:0] & ((7'd1 << ahbls.hsize) - 7'd1)) != 7'd0);
  end

  assign stall     = stall_en ? (lfsr_q[7:0] & STALL_MASK) : 8'd0;
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    word_d  = word_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    err_d   = err_q;
    unique case (state_q)
      StWait: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = err_q ? StErr1 : StData;
        end
      end
      StErr1: state_d = StErr2;
      StIdle, StData, StErr2: begin
        if (accept) begin
          word_d  = ahbls.haddr[OffW +: IdxW];
          off_d   = ahbls.haddr[OffW-1:0];
          size_d  = ahbls.hsize;
          write_d = ahbls.hwrite;
          err_d   = err_in;
          cnt_d   = stall;
          if (stall_en) begin
            lfsr_d = lfsr_step;
          end
          if (stall != 8'd0) begin
            state_d = StWait;
          end else begin
            state_d = err_in ? StErr1 : StData;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      word_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      word_q  <= word_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Read-modify-write merge so only the addressed byte lanes change.
  always_comb begin
    wr_word = mem_q[word_q];
    for (int b = 0; b < int'(NBytes); b++) begin
      lane_mask[b] = (b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q));
      if (lane_mask[b]) begin
        wr_word[8*b +: 8] = ahbls.hwdata[8*b +: 8];
      end
    end
  end

  assign mem_we = (state_q == StData) && write_q;

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[word_q] <= wr_word;
    end
  end

  assign ahbls.hready_resp = ready_int;
  assign ahbls.hresp       = (state_q == StErr1) || (state_q == StErr2);
  assign ahbls.hrdata      = ((state_q == StData) && !write_q) ? mem_q[word_q] : '0;

  logic unused_ok;
  assign unused_ok = ^{ahbls.hburst, ahbls.hprot, ahbls.hmastlock, ahbls.htrans[0]};

endmodule

// File: tb/tb_ahbl_stall_sram.sv
// Randomised self-checking bench for ahbl_stall_sram against a transfer-level reference
// model (byte-lane memory, LFSR sequence, error predicate).
module tb_ahbl_stall_sram;
  localparam int unsigned DEPTH    = 4096;
  localparam logic [31:0] ERR_BASE = 32'hF000_0000;
  localparam logic [31:0] ERR_SIZE = 32'h1000;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_en = 1'b0;
  always #5 clk = ~clk;

  ahbl_stall_sram_if #(.W_ADDR(32), .W_DATA(32)) bus ();
  assign bus.hready = bus.hready_resp;

  ahbl_stall_sram #(
    .W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .STALL_MASK(8'd3), .LFSR_SEED(SEED),
    .ERR_BASE(ERR_BASE), .ERR_SIZE(ERR_SIZE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall_en(stall_en),
    .ahbls(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl_mem [int];
  logic [3:0]  mdl_vld [int];
  logic [15:0] mdl_lfsr = SEED;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return (x % 16'd2 == 16'd1) ? ((x / 16'd2) ^ 16'hB400) : (x / 16'd2);
  endfunction

  function automatic logic in_err(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
    return (a >= ERR_BASE) && ((a - ERR_BASE) < ERR_SIZE);
  endfunction

  // Predicts one transfer and updates model state; call with stall_en as it will be sampled.
  task automatic model_xfer(input logic [31:0] a, input logic w, input logic [2:0] s,
                            input logic [31:0] wd, output int exp_waits, output logic exp_err,
                            output logic [31:0] exp_rd, output logic rd_known);
    int stall;
    int idx;
    int off;
    logic [31:0] word;
    logic [3:0]  vld;
    stall = 0;
    idx = int'((a / 32'd4) % DEPTH);
    off = int'(a % 32'd4);
    exp_err = in_err(a, s);
    if (stall_en) begin
      stall = int'(mdl_lfsr % 16'd4);
      mdl_lfsr = lfsr_adv(mdl_lfsr);
    end
    exp_waits = stall + (exp_err ? 1 : 0);
    exp_rd = '0;
    rd_known = 1'b1;
    word = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'd0;
    vld  = mdl_vld.exists(idx) ? mdl_vld[idx] : 4'd0;
    if (!exp_err && w) begin
      for (int b = 0; b < 4; b++) begin
        if (b >= off && b < off + (1 << s)) begin
          word[8*b +: 8] = wd[8*b +: 8];
          vld[b] = 1'b1;
        end
      end
      mdl_mem[idx] = word;
      mdl_vld[idx] = vld;
    end else if (!exp_err) begin
      exp_rd = word;
      rd_known = (vld == 4'hF);
    end
  endtask

  // Single non-pipelined transfer; starts and ends 1ns after a rising edge.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] s,
                      input logic [31:0] wd, output int waits, output int errlow,
                      output logic last_resp, output logic [31:0] rd);
    logic done;
    bus.haddr  = a;
    bus.hwrite = w;
    bus.hsize  = s;
    bus.htrans = 2'b10;
    @(posedge clk); #1;
    bus.htrans = 2'b00;
    bus.hwdata = wd;
    waits = 0;
    errlow = 0;
    last_resp = 1'b0;
    rd = '0;
    done = 1'b0;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      if (bus.hready_resp === 1'b1) begin
        last_resp = bus.hresp;
        rd = bus.hrdata;
        done = 1'b1;
      end else begin
        waits++;
        if (bus.hresp === 1'b1) errlow++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout addr=%h: no completing data phase within 32 cycles", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl_lfsr = SEED;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.hready_resp !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b resp=%b rdata=%h want 1 0 00000000",
               bus.hready_resp, bus.hresp, bus.hrdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ew;
    logic ee, rk;
    logic [31:0] er;
    stall_en = 1'b0;
    model_xfer(32'h100, 1'b1, 3'd2, 32'hDEAD_BEEF, ew, ee, er, rk);
    model_xfer(32'h100, 1'b0, 3'd2, 32'h0, ew, ee, er, rk);
    bus.haddr = 32'h100; bus.hwrite = 1'b1; bus.hsize = 3'd2; bus.htrans = 2'b10;
    @(posedge clk); #1;
    bus.hwdata = 32'hDEAD_BEEF; bus.hwrite = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.hready_resp !== 1'b1 || bus.hrdata !== 32'd0) begin
      errors++;
      $display("FAIL b2b_write_phase: got rdy=%b rdata=%h want 1 00000000",
               bus.hready_resp, bus.hrdata);
    end
    @(posedge clk); #1;
    bus.htrans = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.hready_resp !== 1'b1 || bus.hrdata !== er) begin
      errors++;
      $display("FAIL b2b_read_phase: got rdy=%b rdata=%h want 1 %h", bus.hready_resp,
               bus.hrdata, er);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    int ew, w, el;
    logic ee, rk, lr;
    logic [31:0] er, rd, junk;
    stall_en = 1'b0;
    junk = $urandom();
    model_xfer(32'h100, 1'b1, 3'd2, 32'h1122_3344, ew, ee, er, rk);
    xfer(32'h100, 1'b1, 3'd2, 32'h1122_3344, w, el, lr, rd);
    model_xfer(32'h103, 1'b1, 3'd0, {8'h5A, junk[23:0]}, ew, ee, er, rk);
    xfer(32'h103, 1'b1, 3'd0, {8'h5A, junk[23:0]}, w, el, lr, rd);
    checks++;
    if (w !== 0 || lr !== 1'b0) begin
      errors++;
      $display("FAIL byte_write_resp: got waits=%0d resp=%b want 0 0", w, lr);
    end
    model_xfer(32'h100, 1'b0, 3'd2, 32'h0, ew, ee, er, rk);
    xfer(32'h100, 1'b0, 3'd2, 32'h0, w, el, lr, rd);
    checks++;
    if (rd !== 32'h5A22_3344) begin
      errors++;
      $display("FAIL byte_write_data: got %h want 5a223344", rd);
    end
  endtask

  task automatic test_errors();
    int ew, w, el;
    logic ee, rk, lr;
    logic [31:0] er, rd;
    logic [31:0] addrs [5] = '{32'hF000_0010, 32'hF000_0100, 32'h101, 32'h100, 32'h102};
    logic [2:0]  sizes [5] = '{3'd2, 3'd2, 3'd1, 3'd3, 3'd2};
    logic        wrs   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    stall_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      model_xfer(addrs[i], wrs[i], sizes[i], 32'hABCD_ABCD, ew, ee, er, rk);
      xfer(addrs[i], wrs[i], sizes[i], 32'hABCD_ABCD, w, el, lr, rd);
      checks++;
      if (w !== 1 || el !== 1 || lr !== 1'b1 || rd !== 32'd0) begin
        errors++;
        $display("FAIL err_resp[%0d] addr=%h: got low=%0d resplow=%0d resp2=%b rd=%h want 1 1 1 0",
                 i, addrs[i], w, el, lr, rd);
      end
    end
    // 0xF000_0100 aliases word 0x40 (byte 0x100): none of the faulted writes may land.
    model_xfer(32'h100, 1'b0, 3'd2, 32'h0, ew, ee, er, rk);
    xfer(32'h100, 1'b0, 3'd2, 32'h0, w, el, lr, rd);
    checks++;
    if (rd !== 32'h5A22_3344) begin
      errors++;
      $display("FAIL err_no_write: got %h want 5a223344", rd);
    end
  endtask

  task automatic test_stall_reads();
    int ew, w, el;
    logic ee, rk, lr;
    logic [31:0] er, rd, v;
    stall_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = $urandom();
      model_xfer(32'h200 + 32'(4*i), 1'b1, 3'd2, v, ew, ee, er, rk);
      xfer(32'h200 + 32'(4*i), 1'b1, 3'd2, v, w, el, lr, rd);
    end
    do_reset();
    stall_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      model_xfer(32'h200 + 32'(4*i), 1'b0, 3'd2, 32'h0, ew, ee, er, rk);
      xfer(32'h200 + 32'(4*i), 1'b0, 3'd2, 32'h0, w, el, lr, rd);
      checks++;
      if (w !== ew || el !== 0 || lr !== 1'b0 || rd !== er) begin
        errors++;
        $display("FAIL stall_read[%0d]: got waits=%0d resplow=%0d resp=%b rd=%h want %0d 0 0 %h",
                 i, w, el, lr, rd, ew, er);
      end
    end
  endtask

  task automatic test_idle_busy();
    int ew, w, el;
    logic ee, rk, lr;
    logic [31:0] er, rd;
    stall_en = 1'b1;
    bus.haddr = 32'h204;
    bus.htrans = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.hready_resp !== 1'b1 || bus.hresp !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold[%0d]: got rdy=%b resp=%b want 1 0", i, bus.hready_resp,
                 bus.hresp);
      end
      @(posedge clk); #1;
    end
    bus.htrans = 2'b00;
    model_xfer(32'h204, 1'b0, 3'd2, 32'h0, ew, ee, er, rk);
    xfer(32'h204, 1'b0, 3'd2, 32'h0, w, el, lr, rd);
    checks++;
    if (w !== ew || rd !== er) begin
      errors++;
      $display("FAIL busy_no_lfsr: got waits=%0d rd=%h want %0d %h", w, rd, ew, er);
    end
  endtask

  task automatic test_stall_reset();
    int ew, w, el;
    logic ee, rk, lr, found;
    logic [31:0] er, rd;
    stall_en = 1'b0;
    model_xfer(32'h300, 1'b1, 3'd2, 32'hCAFE_F00D, ew, ee, er, rk);
    xfer(32'h300, 1'b1, 3'd2, 32'hCAFE_F00D, w, el, lr, rd);
    stall_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (mdl_lfsr % 16'd4 == 16'd3) begin
        found = 1'b1;
      end else begin
        model_xfer(32'h200, 1'b0, 3'd2, 32'h0, ew, ee, er, rk);
        xfer(32'h200, 1'b0, 3'd2, 32'h0, w, el, lr, rd);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall3_search: got no 3-wait LFSR state want one within 64 transfers");
    end
    bus.haddr = 32'h300; bus.hwrite = 1'b1; bus.hsize = 3'd2; bus.htrans = 2'b10;
    @(posedge clk); #1;
    bus.htrans = 2'b00; bus.hwdata = 32'h1111_1111;
    @(negedge clk);
    checks++;
    if (bus.hready_resp !== 1'b0) begin
      errors++;
      $display("FAIL stall3_low: got rdy=%b want 0", bus.hready_resp);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_lfsr = SEED;
    @(negedge clk);
    checks++;
    if (bus.hready_resp !== 1'b1 || bus.hresp !== 1'b0) begin
      errors++;
      $display("FAIL stall3_after_rst: got rdy=%b resp=%b want 1 0", bus.hready_resp,
               bus.hresp);
    end
    @(posedge clk); #1;
    stall_en = 1'b0;
    model_xfer(32'h300, 1'b0, 3'd2, 32'h0, ew, ee, er, rk);
    xfer(32'h300, 1'b0, 3'd2, 32'h0, w, el, lr, rd);
    checks++;
    if (w !== 0 || rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL stall3_dropped_write: got waits=%0d rd=%h want 0 cafef00d", w, rd);
    end
  endtask

  task automatic test_alias();
    int ew, w, el;
    logic ee, rk, lr;
    logic [31:0] er, rd;
    stall_en = 1'b0;
    model_xfer(DEPTH * 4 + 8, 1'b1, 3'd2, 32'h0BAD_CAFE, ew, ee, er, rk);
    xfer(DEPTH * 4 + 8, 1'b1, 3'd2, 32'h0BAD_CAFE, w, el, lr, rd);
    model_xfer(32'h8, 1'b0, 3'd2, 32'h0, ew, ee, er, rk);
    xfer(32'h8, 1'b0, 3'd2, 32'h0, w, el, lr, rd);
    checks++;
    if (rd !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL alias_word2: got %h want 0badcafe", rd);
    end
  endtask

  task automatic test_random();
    int ew, w, el, r;
    logic ee, rk, lr, wr;
    logic [2:0]  s;
    logic [31:0] er, rd, a, wd;
    stall_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom();
      model_xfer(32'h400 + 32'(4*i), 1'b1, 3'd2, wd, ew, ee, er, rk);
      xfer(32'h400 + 32'(4*i), 1'b1, 3'd2, wd, w, el, lr, rd);
    end
    for (int i = 0; i < 48; i++) begin
      stall_en = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom();
      if (r == 0) begin
        a = ERR_BASE + 32'($urandom_range(0, 1023) * 4);
        s = 3'd2;
      end else begin
        a = 32'h400 + 32'($urandom_range(0, 63));
        s = (r == 1) ? 3'd3 : 3'($urandom_range(0, 2));
      end
      model_xfer(a, wr, s, wd, ew, ee, er, rk);
      xfer(a, wr, s, wd, w, el, lr, rd);
      checks++;
      if (w !== ew || el !== (ee ? 1 : 0) || lr !== ee) begin
        errors++;
        $display("FAIL rand_timing[%0d] a=%h s=%0d w=%b: got waits=%0d resplow=%0d resp=%b want %0d %0d %b",
                 i, a, s, wr, w, el, lr, ew, (ee ? 1 : 0), ee);
      end
      if (rk) begin
        checks++;
        if (rd !== er) begin
          errors++;
          $display("FAIL rand_rdata[%0d] a=%h w=%b: got %h want %h", i, a, wr, rd, er);
        end
      end
    end
  endtask

  initial begin
    bus.haddr = '0; bus.hwrite = 1'b0; bus.htrans = 2'b00; bus.hsize = 3'd0;
    bus.hburst = 3'd0; bus.hprot = 4'd0; bus.hmastlock = 1'b0; bus.hwdata = '0;
    #1;
    test_reset();
    test_back_to_back();
    test_byte_write();
    test_errors();
    test_stall_reads();
    test_idle_busy();
    test_stall_reset();
    test_alias();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
